saturating_counter_programmable: RTL and testbench

Parametrised successor to the basic saturating up/down counter. Supports multi-unit increment/decrement steps, simultaneous increment and decrement with net arithmetic, and synchronous load. Provides boundary status outputs and sticky saturation-event flags. Used for confidence/credit tracking (branch predictor tables, QoS credit counters, error-rate monitors) where steps larger than one and clipping visibility are required.

---
 rtl/saturating_counter_programmable.sv | 100 ++++++++++
 tb/tb_saturating_counter_programmable.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/saturating_counter_programmable.sv
// Programmable saturating up/down counter with multi-unit steps,
// synchronous load, boundary status and sticky clip flags.
module saturating_counter_programmable #(
  parameter int RANGE       = 4,
  parameter int RANGE_LOG2  = $clog2(RANGE),
  parameter int RESET_VALUE = 0,
  parameter int STEP_WIDTH  = 2
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  increment,
  input  logic [STEP_WIDTH-1:0] increment_amount,
  input  logic                  decrement,
  input  logic [STEP_WIDTH-1:0] decrement_amount,
  input  logic                  load,
  input  logic [RANGE_LOG2-1:0] load_value,
  input  logic                  clear_flags,
  output logic [RANGE_LOG2-1:0] count,
  output logic                  minimum,
  output logic                  maximum,
  output logic                  saturated_high,
  output logic                  saturated_low
);

  localparam int DW = RANGE_LOG2 + STEP_WIDTH + 2;

  localparam logic [RANGE_LOG2-1:0] MAX_C =
    RANGE_LOG2'(RANGE - 1);
  localparam logic [RANGE_LOG2-1:0] RST_C =
    RANGE_LOG2'(RESET_VALUE);
  localparam logic signed [DW-1:0] MAX_S =
    DW'(RANGE - 1);

  logic [RANGE_LOG2-1:0] count_q, count_d;
  logic                  sat_hi_q, sat_hi_d;
  logic                  sat_lo_q, sat_lo_d;

  logic signed [DW-1:0] inc_ext;
  logic signed [DW-1:0] dec_ext;
  logic signed [DW-1:0] cnt_ext;
  logic signed [DW-1:0] next_s;
  logic                 clip_hi;
  logic                 clip_lo;
  logic [RANGE_LOG2:0]  load_ext;

  // Wide signed sum so no combination of steps can wrap.
  always_comb begin
    inc_ext = '0;
    dec_ext = '0;
    if (increment) begin
      inc_ext = {{(DW-STEP_WIDTH){1'b0}}, increment_amount};
    end
    if (decrement) begin
      dec_ext = {{(DW-STEP_WIDTH){1'b0}}, decrement_amount};
    end
    cnt_ext  = {{(DW-RANGE_LOG2){1'b0}}, count_q};
    next_s   = cnt_ext + inc_ext - dec_ext;
    clip_hi  = !load && (next_s > MAX_S);
    clip_lo  = !load && (next_s < 0);
    load_ext = {1'b0, load_value};
  end

  always_comb begin
    count_d = count_q;
    if (load) begin
      if (load_ext > {1'b0, MAX_C}) begin
        count_d = MAX_C;
      end else begin
        count_d = load_value;
      end
    end else if (clip_hi) begin
      count_d = MAX_C;
    end else if (clip_lo) begin
      count_d = '0;
    end else begin
      count_d = next_s[RANGE_LOG2-1:0];
    end
    sat_hi_d = clip_hi | (sat_hi_q & ~clear_flags);
    sat_lo_d = clip_lo | (sat_lo_q & ~clear_flags);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      count_q  <= RST_C;
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      sat_hi_q <= sat_hi_d;
      sat_lo_q <= sat_lo_d;
    end
  end

  assign count          = count_q;
  assign minimum        = (count_q == '0);
  assign maximum        = (count_q == MAX_C);
  assign saturated_high = sat_hi_q;
  assign saturated_low  = sat_lo_q;

endmodule

// File: tb/tb_saturating_counter_programmable.sv
// Bench for saturating_counter_programmable: directed plan
// scenarios then randomized traffic against an arithmetic model.
module tb_saturating_counter_programmable;

  localparam int RANGE = 6;
  localparam int SW    = 3;
  localparam int RV    = 2;
  localparam int LW    = $clog2(RANGE);

  logic          clock = 1'b0;
  logic          resetn;
  logic          increment;
  logic [SW-1:0] increment_amount;
  logic          decrement;
  logic [SW-1:0] decrement_amount;
  logic          load;
  logic [LW-1:0] load_value;
  logic          clear_flags;
  logic [LW-1:0] count;
  logic          minimum;
  logic          maximum;
  logic          saturated_high;
  logic          saturated_low;

  int n_chk  = 0;
  int n_pass = 0;

  int m_cnt;
  bit m_hi;
  bit m_lo;

  always #5 clock = ~clock;

  saturating_counter_programmable #(
    .RANGE      (RANGE),
    .RESET_VALUE(RV),
    .STEP_WIDTH (SW)
  ) dut (
    .clock           (clock),
    .resetn          (resetn),
    .increment       (increment),
    .increment_amount(increment_amount),
    .decrement       (decrement),
    .decrement_amount(decrement_amount),
    .load            (load),
    .load_value      (load_value),
    .clear_flags     (clear_flags),
    .count           (count),
    .minimum         (minimum),
    .maximum         (maximum),
    .saturated_high  (saturated_high),
    .saturated_low   (saturated_low)
  );

  task automatic check(input string tag,
                       input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d",
                  tag, obs, exp);
  endtask

  // Reference: plain integer arithmetic on the rules.
  task automatic model();
    int  n;
    bit  ch, cl;
    ch = 0;
    cl = 0;
    if (!resetn) begin
      m_cnt = RV;
      m_hi  = 0;
      m_lo  = 0;
    end else begin
      if (load) begin
        m_cnt = (int'(load_value) > RANGE - 1)
              ? RANGE - 1 : int'(load_value);
      end else begin
        n = m_cnt;
        if (increment) n += int'(increment_amount);
        if (decrement) n -= int'(decrement_amount);
        if (n > RANGE - 1) begin
          m_cnt = RANGE - 1;
          ch = 1;
        end else if (n < 0) begin
          m_cnt = 0;
          cl = 1;
        end else begin
          m_cnt = n;
        end
      end
      m_hi = ch || (m_hi && !clear_flags);
      m_lo = cl || (m_lo && !clear_flags);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".cnt"}, int'(count), m_cnt);
    check({tag, ".min"}, int'(minimum), int'(m_cnt == 0));
    check({tag, ".max"}, int'(maximum),
          int'(m_cnt == RANGE - 1));
    check({tag, ".hi"}, int'(saturated_high), int'(m_hi));
    check({tag, ".lo"}, int'(saturated_low), int'(m_lo));
  endtask

  task automatic cyc(input bit rn,
                     input bit inc, input int ia,
                     input bit dec, input int da,
                     input bit ld, input int lv,
                     input bit clr, input string tag);
    resetn           = rn;
    increment        = inc;
    increment_amount = SW'(ia);
    decrement        = dec;
    decrement_amount = SW'(da);
    load             = ld;
    load_value       = LW'(lv);
    clear_flags      = clr;
    @(posedge clock);
    model();
    #1;
    check_all(tag);
  endtask

  initial begin
    m_cnt = 0;
    m_hi  = 0;
    m_lo  = 0;
    cyc(0, 0,0, 0,0, 0,0, 0, "rst");
    cyc(1, 0,0, 0,0, 0,0, 0, "idle");
    check("t1_cnt", int'(count), 2);
    check("t1_flags", int'({saturated_high,
          saturated_low, minimum, maximum}), 0);

    cyc(1, 1,3, 0,0, 0,0, 0, "inc3");
    check("t2_max", int'(maximum), 1);
    cyc(1, 1,1, 0,0, 0,0, 0, "clip_hi");
    check("t2_hi", int'(saturated_high), 1);
    cyc(1, 1,0, 0,0, 0,0, 0, "inc0");

    cyc(1, 1,2, 1,5, 0,0, 0, "net_m3");
    check("t3_cnt", int'(count), 2);
    cyc(1, 1,1, 1,4, 0,0, 0, "clip_lo");
    check("t3_lo", int'(saturated_low), 1);
    cyc(1, 1,3, 1,3, 0,0, 0, "cancel");

    cyc(1, 0,0, 0,0, 1,7, 0, "ld_clamp");
    check("t4_cnt", int'(count), 5);
    cyc(1, 1,4, 0,0, 1,1, 0, "ld_wins");
    check("t4_ldw", int'(count), 1);

    cyc(1, 0,0, 0,0, 0,0, 1, "clr");
    check("t5_clr", int'({saturated_high,
          saturated_low}), 0);
    cyc(1, 0,0, 0,0, 1,5, 0, "ld5");
    cyc(1, 1,2, 0,0, 0,0, 1, "set_wins");
    check("t5_hi", int'(saturated_high), 1);

    cyc(1, 0,0, 0,0, 1,0, 0, "ld0");
    cyc(1, 0,0, 1,1, 0,0, 0, "clip_lo2");
    cyc(1, 0,0, 0,0, 1,4, 0, "ld4");
    cyc(0, 1,1, 0,0, 0,0, 0, "mid_rst");
    check("t6_rst", int'(count), 2);
    cyc(1, 1,1, 0,0, 0,0, 0, "post_rst");
    check("t6_cnt", int'(count), 3);

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 24) != 0),
          $urandom_range(0, 1), $urandom_range(0, 7),
          $urandom_range(0, 1), $urandom_range(0, 7),
          ($urandom_range(0, 7) == 0),
          $urandom_range(0, 7),
          ($urandom_range(0, 5) == 0), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
